// File: rtl/safety_island_timer_array_pkg.sv
// Shared definitions for the safety island timer array: register map
// offsets, address strides, CFG field positions and the per-channel
// configuration record with its pack/unpack helpers.
package safety_island_timer_array_pkg;

   localparam logic [3:0] RegCfgOff    = 4'h0;
   localparam logic [3:0] RegCntOff    = 4'h4;
   localparam logic [3:0] RegCmpOff    = 4'h8;
   localparam logic [3:0] RegStatusOff = 4'hC;

   localparam int unsigned TimerStride = 32'h20;
   localparam int unsigned ChanStride  = 32'h10;

   localparam int unsigned CfgEnBit      = 0;
   localparam int unsigned CfgOneshotBit = 1;
   localparam int unsigned CfgCascadeBit = 2;
   localparam int unsigned CfgIrqenBit   = 3;
   localparam int unsigned CfgPrescLsb   = 8;

   typedef struct packed {
      logic [7:0] presc;
      logic       irqen;
      logic       cascade;
      logic       oneshot;
      logic       en;
   } timer_chan_cfg_t;

   // Interrupt count follows the instantiated timer count: two channels per timer.
   localparam int unsigned DefaultNumTimers = 1;

   function automatic int unsigned num_timer_interrupts(input int unsigned num_timers);
      return 2 * num_timers;
   endfunction

   localparam int unsigned NumTimerInterrupts = num_timer_interrupts(DefaultNumTimers);

   // CASCADE only exists on hi channels; on lo it is dropped so it reads 0.
   function automatic timer_chan_cfg_t cfg_unpack(input logic [31:0] w, input logic is_hi);
      timer_chan_cfg_t c;
      c.en      = w[CfgEnBit];
      c.oneshot = w[CfgOneshotBit];
      c.cascade = w[CfgCascadeBit] & is_hi;
      c.irqen   = w[CfgIrqenBit];
      c.presc   = w[CfgPrescLsb +: 8];
      return c;
   endfunction

   function automatic logic [31:0] cfg_pack(input timer_chan_cfg_t c);
      return {16'h0000, c.presc, 4'h0, c.irqen, c.cascade, c.oneshot, c.en};
   endfunction

endpackage

// File: rtl/safety_island_timer_channel.sv
// One timer counter channel: prescaler, CNT/CMP compare, PEND flag,
// tick source select (own prescaler or cascade input) and match output.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   cfg/cnt/cmp/status_we_i  register write strobes, data on wdata_i
//   cascade_tick_i         lo channel match (used by hi channel when CASCADE)
//   cfg_o, cnt_o, cmp_o, pend_o  register state for readback
//   match_o                combinational match event this cycle
//   irq_o                  PEND & IRQEN
module safety_island_timer_channel
   import safety_island_timer_array_pkg::*;
#(
   parameter int unsigned CntWidth = 32,
   parameter bit          IsHi     = 1'b0
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                cfg_we_i,
   input  logic                cnt_we_i,
   input  logic                cmp_we_i,
   input  logic                status_we_i,
   input  logic [31:0]         wdata_i,
   input  logic                cascade_tick_i,
   output timer_chan_cfg_t     cfg_o,
   output logic [CntWidth-1:0] cnt_o,
   output logic [CntWidth-1:0] cmp_o,
   output logic                pend_o,
   output logic                match_o,
   output logic                irq_o
);

   timer_chan_cfg_t     cfg_q, cfg_d, cfg_new;
   logic [CntWidth-1:0] cnt_q, cnt_d;
   logic [CntWidth-1:0] cmp_q, cmp_d;
   logic                pend_q, pend_d;
   logic [7:0]          psc_q, psc_d;
   logic                use_cascade, tick, match;
   logic                unused_wdata;

   assign unused_wdata = ^wdata_i;

   // Prescaler is a down-counter holding the cycles left before the next
   // tick; it is reloaded with PRESC on enable and after every tick, so
   // ticks land every PRESC+1 cycles.
   always_comb begin
      cfg_d   = cfg_q;
      cnt_d   = cnt_q;
      cmp_d   = cmp_q;
      pend_d  = pend_q;
      psc_d   = psc_q;
      cfg_new = cfg_unpack(wdata_i, IsHi);

      use_cascade = IsHi && cfg_q.cascade;
      tick        = cfg_q.en && (use_cascade ? cascade_tick_i : (psc_q == 8'd0));
      match       = tick && (cnt_q == cmp_q);

      if (cfg_q.en && !use_cascade) begin
         psc_d = (psc_q == 8'd0) ? cfg_q.presc : psc_q - 8'd1;
      end

      // Clear comes before the match set so a same-cycle match keeps PEND.
      if (status_we_i && wdata_i[0]) begin
         pend_d = 1'b0;
      end

      if (tick) begin
         if (match) begin
            cnt_d  = '0;
            pend_d = 1'b1;
            if (cfg_q.oneshot) begin
               cfg_d.en = 1'b0;
            end
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      if (cfg_we_i) begin
         cfg_d = cfg_new;
         if (!cfg_new.en) begin
            psc_d = 8'd0;
         end else if (!cfg_q.en) begin
            psc_d = cfg_new.presc;
         end
      end

      if (cnt_we_i) begin
         cnt_d = wdata_i[CntWidth-1:0];
      end

      if (cmp_we_i) begin
         cmp_d = wdata_i[CntWidth-1:0];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cfg_q  <= '0;
         cnt_q  <= '0;
         cmp_q  <= '0;
         pend_q <= 1'b0;
         psc_q  <= 8'd0;
      end else begin
         cfg_q  <= cfg_d;
         cnt_q  <= cnt_d;
         cmp_q  <= cmp_d;
         pend_q <= pend_d;
         psc_q  <= psc_d;
      end
   end

   assign cfg_o   = cfg_q;
   assign cnt_o   = cnt_q;
   assign cmp_o   = cmp_q;
   assign pend_o  = pend_q;
   assign match_o = match;
   assign irq_o   = pend_q & cfg_q.irqen;

endmodule

// File: rtl/safety_island_timer_array.sv
// Multi-timer unit: NumTimers timers, each with a lo and a hi channel,
// behind a simple register bus with a registered one-cycle response.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_*_i               register request (valid, write, byte addr, wdata)
//   rsp_valid_o/rdata_o/error_o  response, one cycle after the request
//   irq_o                 level interrupts, bit 2t = timer t lo, 2t+1 = hi
module safety_island_timer_array
   import safety_island_timer_array_pkg::*;
#(
   parameter int unsigned NumTimers = 1,
   parameter int unsigned CntWidth  = 32,
   parameter int unsigned AddrWidth = 12
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   req_valid_i,
   input  logic                   req_write_i,
   input  logic [AddrWidth-1:0]   req_addr_i,
   input  logic [31:0]            req_wdata_i,
   output logic                   rsp_valid_o,
   output logic [31:0]            rsp_rdata_o,
   output logic                   rsp_error_o,
   output logic [2*NumTimers-1:0] irq_o
);

   localparam int unsigned NumChan  = num_timer_interrupts(NumTimers);
   localparam int unsigned IdxWidth = AddrWidth - 5;

   logic [IdxWidth-1:0] req_idx;
   logic                req_chan;
   logic [3:0]          req_off;
   logic                idx_ok, addr_ok, wr_ok;

   // Address layout: [AddrWidth-1:5] timer, [4] channel, [3:0] register.
   assign req_idx  = req_addr_i[AddrWidth-1:5];
   assign req_chan = req_addr_i[4];
   assign req_off  = req_addr_i[3:0];
   assign idx_ok   = 32'(req_idx) < NumTimers;
   assign addr_ok  = idx_ok && (req_addr_i[1:0] == 2'b00);
   assign wr_ok    = req_valid_i && req_write_i && addr_ok;

   timer_chan_cfg_t     cfg   [NumChan];
   logic [CntWidth-1:0] cnt   [NumChan];
   logic [CntWidth-1:0] cmp   [NumChan];
   logic [NumChan-1:0]  pend, match, irq, casc;

   for (genvar i = 0; i < NumChan; i++) begin : g_chan
      localparam bit IsHi = (i % 2) == 1;
      logic sel;

      assign sel = wr_ok && (32'(req_idx) == i / 2) && (req_chan == IsHi);

      // Hi channel's cascade source is the lo channel of the same timer.
      if (IsHi) begin : g_casc
         assign casc[i] = match[i-1];
      end else begin : g_nocasc
         assign casc[i] = 1'b0;
      end

      safety_island_timer_channel #(
         .CntWidth (CntWidth),
         .IsHi     (IsHi)
      ) u_chan (
         .clk_i          (clk_i),
         .rst_i          (rst_i),
         .cfg_we_i       (sel && (req_off == RegCfgOff)),
         .cnt_we_i       (sel && (req_off == RegCntOff)),
         .cmp_we_i       (sel && (req_off == RegCmpOff)),
         .status_we_i    (sel && (req_off == RegStatusOff)),
         .wdata_i        (req_wdata_i),
         .cascade_tick_i (casc[i]),
         .cfg_o          (cfg[i]),
         .cnt_o          (cnt[i]),
         .cmp_o          (cmp[i]),
         .pend_o         (pend[i]),
         .match_o        (match[i]),
         .irq_o          (irq[i])
      );
   end

   logic [31:0] rd_val;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_error_q, rsp_error_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;

   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NumChan; i++) begin
         if ((32'(req_idx) == i / 2) && (req_chan == ((i % 2) == 1))) begin
            case (req_off)
               RegCfgOff:    rd_val = cfg_pack(cfg[i]);
               RegCntOff:    rd_val = 32'(cnt[i]);
               RegCmpOff:    rd_val = 32'(cmp[i]);
               RegStatusOff: rd_val = {31'b0, pend[i]};
               default:      rd_val = '0;
            endcase
         end
      end
   end

   always_comb begin
      rsp_valid_d = req_valid_i;
      rsp_error_d = req_valid_i && !addr_ok;
      rsp_rdata_d = (req_valid_i && !req_write_i && addr_ok) ? rd_val : 32'h0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rsp_valid_q <= 1'b0;
         rsp_error_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_error_q <= rsp_error_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_error_o = rsp_error_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign irq_o       = irq;

endmodule

// File: tb/tb_safety_island_timer_array.sv
// Directed self-checking bench for safety_island_timer_array with two
// timers. Inputs change on the falling edge; outputs are sampled there.
module tb_safety_island_timer_array;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_write_i = 1'b0;
   logic [11:0] req_addr_i = '0;
   logic [31:0] req_wdata_i = '0;
   logic        rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic        rsp_error_o;
   logic [3:0]  irq_o;

   int n_tests = 0;
   int n_fail  = 0;

   safety_island_timer_array #(
      .NumTimers (2),
      .CntWidth  (32),
      .AddrWidth (12)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_write_i (req_write_i),
      .req_addr_i  (req_addr_i),
      .req_wdata_i (req_wdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_error_o (rsp_error_o),
      .irq_o       (irq_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      wait_cyc(2);
      rst_i = 1'b0;
   endtask

   // Called at a falling edge; the request is accepted at the next rising
   // edge and the response is sampled at the falling edge after it.
   task automatic bus_write(input logic [11:0] a, input logic [31:0] d, input logic exp_err);
      req_valid_i = 1'b1;
      req_write_i = 1'b1;
      req_addr_i  = a;
      req_wdata_i = d;
      @(negedge clk_i);
      check_eq("wr_rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
      check_eq("wr_rsp_error", {31'b0, rsp_error_o}, {31'b0, exp_err});
      check_eq("wr_rsp_rdata", rsp_rdata_o, 32'h0);
      req_valid_i = 1'b0;
      req_write_i = 1'b0;
   endtask

   task automatic bus_read(input logic [11:0] a, output logic [31:0] d, output logic e);
      req_valid_i = 1'b1;
      req_write_i = 1'b0;
      req_addr_i  = a;
      req_wdata_i = '0;
      @(negedge clk_i);
      check_eq("rd_rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
      d = rsp_rdata_o;
      e = rsp_error_o;
      req_valid_i = 1'b0;
   endtask

   task automatic read_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
      logic [31:0] d;
      logic        e;
      bus_read(a, d, e);
      check_eq(tag, d, exp);
      check_eq({tag, "_err"}, {31'b0, e}, 32'd0);
   endtask

   task automatic read_err(input string tag, input logic [11:0] a);
      logic [31:0] d;
      logic        e;
      bus_read(a, d, e);
      check_eq({tag, "_err"}, {31'b0, e}, 32'd1);
      check_eq({tag, "_rdata"}, d, 32'h0);
   endtask

   initial begin
      logic [11:0] bases [4];
      bases = '{12'h000, 12'h010, 12'h020, 12'h030};

      // Reset state, response only after a request
      wait_cyc(3);
      rst_i = 1'b0;
      wait_cyc(1);
      check_eq("rst_valid", {31'b0, rsp_valid_o}, 32'd0);
      check_eq("rst_error", {31'b0, rsp_error_o}, 32'd0);
      check_eq("rst_rdata", rsp_rdata_o, 32'h0);
      check_eq("rst_irq", {28'b0, irq_o}, 32'h0);
      for (int b = 0; b < 4; b++) begin
         for (int r = 0; r < 4; r++) begin
            read_chk("rst_reg", bases[b] + 12'(4 * r), 32'h0);
         end
      end
      wait_cyc(1);
      check_eq("idle_valid", {31'b0, rsp_valid_o}, 32'd0);

      // CFG readback: unused bits 0, CASCADE only on hi
      do_reset();
      bus_write(12'h000, 32'hFFFF_FFFF, 1'b0);
      read_chk("cfg_lo_rb", 12'h000, 32'h0000_FF0B);
      bus_write(12'h010, 32'hFFFF_FFFF, 1'b0);
      read_chk("cfg_hi_rb", 12'h010, 32'h0000_FF0F);

      // Lo continuous: PRESC=3, CMP=4 -> match every 20 cycles
      do_reset();
      bus_write(12'h008, 32'd4, 1'b0);
      bus_write(12'h000, 32'h0000_0309, 1'b0);
      wait_cyc(19);
      check_eq("lo_irq_before", {28'b0, irq_o}, 32'h0);
      wait_cyc(1);
      check_eq("lo_irq_match1", {28'b0, irq_o}, 32'h1);
      bus_write(12'h00C, 32'd1, 1'b0);
      check_eq("lo_irq_cleared", {28'b0, irq_o}, 32'h0);
      wait_cyc(18);
      check_eq("lo_irq_before2", {28'b0, irq_o}, 32'h0);
      wait_cyc(1);
      check_eq("lo_irq_match2", {28'b0, irq_o}, 32'h1);

      // One-shot: PRESC=0, CMP=2 -> single match at cycle 3
      do_reset();
      bus_write(12'h008, 32'd2, 1'b0);
      bus_write(12'h000, 32'h0000_000B, 1'b0);
      wait_cyc(2);
      check_eq("os_irq_before", {28'b0, irq_o}, 32'h0);
      wait_cyc(1);
      check_eq("os_irq_match", {28'b0, irq_o}, 32'h1);
      wait_cyc(5);
      read_chk("os_cfg_en_off", 12'h000, 32'h0000_000A);
      read_chk("os_cnt_zero", 12'h004, 32'h0);

      // Cascade: lo CMP=1 every 2 cycles, hi CMP=2 every 6 cycles
      do_reset();
      bus_write(12'h018, 32'd2, 1'b0);
      bus_write(12'h010, 32'h0000_000D, 1'b0);
      bus_write(12'h008, 32'd1, 1'b0);
      bus_write(12'h000, 32'h0000_0009, 1'b0);
      wait_cyc(5);
      check_eq("casc_irq_c6", {28'b0, irq_o}, 32'h1);
      wait_cyc(1);
      check_eq("casc_irq_c7", {28'b0, irq_o}, 32'h3);
      bus_write(12'h00C, 32'd1, 1'b0);
      bus_write(12'h01C, 32'd1, 1'b0);
      wait_cyc(3);
      check_eq("casc_irq_c12", {28'b0, irq_o}, 32'h1);
      wait_cyc(1);
      check_eq("casc_irq_c13", {28'b0, irq_o}, 32'h3);

      // STATUS clear in the match cycle keeps PEND; elsewhere it clears
      do_reset();
      bus_write(12'h008, 32'd2, 1'b0);
      bus_write(12'h000, 32'h0000_0009, 1'b0);
      wait_cyc(5);
      bus_write(12'h00C, 32'd1, 1'b0);
      read_chk("clr_vs_match", 12'h00C, 32'd1);
      bus_write(12'h00C, 32'd1, 1'b0);
      read_chk("clr_no_match", 12'h00C, 32'd0);

      // CNT write against a tick every cycle: write wins
      do_reset();
      bus_write(12'h008, 32'h100, 1'b0);
      bus_write(12'h000, 32'h0000_0001, 1'b0);
      wait_cyc(3);
      bus_write(12'h004, 32'h10, 1'b0);
      read_chk("cnt_wr_wins", 12'h004, 32'h10);
      read_chk("cnt_after_wr", 12'h004, 32'h11);

      // Errors: out-of-range timer, unaligned; no state change
      do_reset();
      read_err("err_idx2", 12'h040);
      read_err("err_unal", 12'h003);
      read_err("err_idx2_sts", 12'h05C);
      bus_write(12'h048, 32'd5, 1'b1);
      bus_write(12'h040, 32'h0000_0009, 1'b1);
      bus_write(12'h00A, 32'hFF, 1'b1);
      read_chk("err_cmp_kept", 12'h008, 32'h0);
      read_chk("err_cfg_kept", 12'h000, 32'h0);
      wait_cyc(4);
      check_eq("err_irq", {28'b0, irq_o}, 32'h0);

      // Reset asserted with a request in flight drops the response
      req_valid_i = 1'b1;
      req_write_i = 1'b0;
      req_addr_i  = 12'h000;
      rst_i       = 1'b1;
      @(negedge clk_i);
      check_eq("rst_drop_valid", {31'b0, rsp_valid_o}, 32'd0);
      req_valid_i = 1'b0;
      rst_i       = 1'b0;
      wait_cyc(1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
